// File: rtl/fft_agu_pkg.sv
// fft_agu_pkg: shared definitions for the parametrised FFT address-generation unit.
//  - parameter limits for LOG2N / PIPE_LAT
//  - FSM state encoding (IDLE/RUN/DRAIN/DONE)
//  - rotl(): rotate-left within an n-bit field
//  - tw_mask(): twiddle index mask for a given stage
package fft_agu_pkg;

    localparam int unsigned LOG2N_MIN    = 2;
    localparam int unsigned LOG2N_MAX    = 12;
    localparam int unsigned PIPE_LAT_MIN = 1;
    localparam int unsigned PIPE_LAT_MAX = 15;

    localparam int unsigned STATE_W = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Containers sized for the largest legal transform; callers truncate.
    typedef logic [LOG2N_MAX-1:0] agu_addr_t;
    typedef logic [LOG2N_MAX-2:0] agu_tw_t;

    // Low n bits set.
    function automatic agu_addr_t field_mask(input int unsigned n);
        return agu_addr_t'((64'(1) << n) - 64'(1));
    endfunction

    // Rotate x left by sh positions inside an n-bit field (sh < n).
    function automatic agu_addr_t rotl(input agu_addr_t x, input int unsigned sh,
                                       input int unsigned n);
        agu_addr_t m;
        agu_addr_t r;
        m = field_mask(n);
        r = x & m;
        for (int unsigned k = 0; k < LOG2N_MAX; k++) begin
            if (k < sh) begin
                r = ((r << 1) | (r >> (n - 1))) & m;
            end
        end
        return r;
    endfunction

    // The s most-significant bits of an (n-1)-bit twiddle index; stage 0 gives zero.
    function automatic agu_tw_t tw_mask(input int unsigned s, input int unsigned n);
        logic [63:0] full;
        logic [63:0] low;
        full = (64'(1) << (n - 1)) - 64'(1);
        low  = (64'(1) << (n - 1 - s)) - 64'(1);
        return agu_tw_t'(full & ~low);
    endfunction

endpackage

// File: rtl/fft_agu_delay_line.sv
// fft_agu_delay_line: DEPTH-stage shift register with shift enable and async clear.
//  Ports: clk, rst_n (async active-low clear), en (shift), d [W-1:0] in, q [W-1:0] out.
//  q equals d from DEPTH enabled edges earlier.
module fft_agu_delay_line
    import fft_agu_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [DEPTH*W-1:0] sr_q;
    logic [DEPTH*W-1:0] sr_d;
    logic [DEPTH*W-1:0] shifted;

    // New sample enters the low slot; the oldest sits in the top slot.
    if (DEPTH == 1) begin : g_one
        assign shifted = d;
    end else begin : g_many
        assign shifted = {sr_q[(DEPTH-1)*W-1:0], d};
    end

    always_comb begin
        sr_d = sr_q;
        if (en) begin
            sr_d = shifted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q[DEPTH*W-1 -: W];

endmodule

// File: rtl/fft_agu_param.sv
// fft_agu_param: address-generation unit for an in-place radix-2 DIT FFT.
//  Walks LOG2N stages of N/2 butterflies, issuing read addresses, twiddle
//  index and bank select, then the matching write addresses PIPE_LAT cycles
//  later. A drain gap after each stage keeps stage s+1 reads behind stage s
//  writes.
//  Ports:
//   clk, rst_n             clock, async active-low reset
//   start_fft              start request (only honoured while idle)
//   stall                  present only with FFT_AGU_STALL_EN; freezes sequencing
//   busy                   accept through the fft_done cycle
//   rd_valid, rd_a_addr, rd_b_addr, twiddle_addr, rd_bank   read issue
//   wr_en, wr_a_addr, wr_b_addr, wr_bank                    delayed write issue
//   fft_done               one-cycle completion pulse
//  Build option: define FFT_AGU_STALL_EN to add the stall input.
module fft_agu_param
    import fft_agu_pkg::*;
#(
    parameter int unsigned LOG2N    = 5,
    parameter int unsigned PIPE_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_fft,
`ifdef FFT_AGU_STALL_EN
    input  logic             stall,
`endif
    output logic             busy,
    output logic             rd_valid,
    output logic [LOG2N-1:0] rd_a_addr,
    output logic [LOG2N-1:0] rd_b_addr,
    output logic [LOG2N-2:0] twiddle_addr,
    output logic             rd_bank,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_a_addr,
    output logic [LOG2N-1:0] wr_b_addr,
    output logic             wr_bank,
    output logic             fft_done
);

    localparam int unsigned AW     = LOG2N;
    localparam int unsigned J_W    = LOG2N - 1;
    localparam int unsigned S_W    = 4;
    localparam int unsigned DRN_W  = 4;
    localparam int unsigned N_HALF = 2 ** (LOG2N - 1);
    localparam int unsigned DL_W   = 2 * AW + 2;

    localparam logic [J_W-1:0]   J_LAST   = J_W'(N_HALF - 1);
    localparam logic [S_W-1:0]   S_LAST   = S_W'(LOG2N - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT - 1);

    if (LOG2N < LOG2N_MIN || LOG2N > LOG2N_MAX ||
        PIPE_LAT < PIPE_LAT_MIN || PIPE_LAT > PIPE_LAT_MAX) begin : g_bad_cfg
        $error("fft_agu_param: LOG2N or PIPE_LAT out of range");
    end

    logic stall_i;
`ifdef FFT_AGU_STALL_EN
    assign stall_i = stall;
`else
    assign stall_i = 1'b0;
`endif

    logic [STATE_W-1:0] state_q, state_d;
    logic [S_W-1:0]     s_q, s_d;
    logic [J_W-1:0]     j_q, j_d;
    logic [DRN_W-1:0]   drn_q, drn_d;

    logic               rd_valid_q, rd_valid_d;
    logic [AW-1:0]      rd_a_q, rd_a_d;
    logic [AW-1:0]      rd_b_q, rd_b_d;
    logic [J_W-1:0]     tw_q, tw_d;
    logic               rd_bank_q, rd_bank_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [DL_W-1:0]    dl_in;
    logic [DL_W-1:0]    dl_out;
    logic               wr_valid_raw;

    // Sequencer and registered read issue; everything holds while stalled.
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        j_d        = j_q;
        drn_d      = drn_q;
        rd_valid_d = rd_valid_q;
        rd_a_d     = rd_a_q;
        rd_b_d     = rd_b_q;
        tw_d       = tw_q;
        rd_bank_d  = rd_bank_q;
        busy_d     = busy_q;
        done_d     = done_q;

        if (!stall_i) begin
            rd_valid_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_fft) begin
                        state_d = ST_RUN;
                        s_d     = '0;
                        j_d     = '0;
                        drn_d   = '0;
                    end
                end
                ST_RUN: begin
                    rd_valid_d = 1'b1;
                    rd_a_d     = AW'(rotl(agu_addr_t'({j_q, 1'b0}), 32'(s_q), LOG2N));
                    rd_b_d     = AW'(rotl(agu_addr_t'({j_q, 1'b1}), 32'(s_q), LOG2N));
                    tw_d       = j_q & J_W'(tw_mask(32'(s_q), LOG2N));
                    rd_bank_d  = s_q[0];
                    if (j_q == J_LAST) begin
                        state_d = ST_DRAIN;
                        j_d     = '0;
                        drn_d   = '0;
                    end else begin
                        j_d = j_q + J_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Wait out the write pipeline before the next stage reads.
                    if (drn_q == DRN_LAST) begin
                        drn_d = '0;
                        if (s_q == S_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            s_d     = s_q + S_W'(1);
                            state_d = ST_RUN;
                        end
                    end else begin
                        drn_d = drn_q + DRN_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            // busy spans the cycle in which fft_done is presented.
            busy_d = (state_d != ST_IDLE) || (state_q == ST_DONE);
            done_d = (state_q == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            j_q        <= '0;
            drn_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            tw_q       <= '0;
            rd_bank_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            j_q        <= j_d;
            drn_q      <= drn_d;
            rd_valid_q <= rd_valid_d;
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
            tw_q       <= tw_d;
            rd_bank_q  <= rd_bank_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Write side is a pure delay of the read issue; write bank is the other bank.
    assign dl_in = {rd_valid_q, rd_a_q, rd_b_q, ~rd_bank_q};

    fft_agu_delay_line #(
        .W     (DL_W),
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!stall_i),
        .d     (dl_in),
        .q     (dl_out)
    );

    assign {wr_valid_raw, wr_a_addr, wr_b_addr, wr_bank} = dl_out;

    // Held entries are hidden while stalled so each one is seen exactly once.
    assign rd_valid     = rd_valid_q & ~stall_i;
    assign wr_en        = wr_valid_raw & ~stall_i;
    assign fft_done     = done_q & ~stall_i;
    assign busy         = busy_q;
    assign rd_a_addr    = rd_a_q;
    assign rd_b_addr    = rd_b_q;
    assign twiddle_addr = tw_q;
    assign rd_bank      = rd_bank_q;

endmodule

// File: tb/tb_fft_agu_param.sv
// tb_fft_agu_param: directed bench for fft_agu_param at LOG2N=5, PIPE_LAT=4.
//  A negedge monitor checks every read against a stage/index model and every
//  write against the queued read four unstalled cycles earlier.
module tb_fft_agu_param;

    localparam int LOG2N    = 5;
    localparam int PIPE_LAT = 4;
    localparam int NH       = 16;
    localparam int NRD      = LOG2N * NH;
    localparam int RUN_LEN  = LOG2N * (NH + PIPE_LAT) + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_fft = 1'b0;
    logic       stall = 1'b0;
    logic       busy, rd_valid, rd_bank, wr_en, wr_bank, fft_done;
    logic [4:0] rd_a_addr, rd_b_addr, wr_a_addr, wr_b_addr;
    logic [3:0] twiddle_addr;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc = 0, ucyc = 0, stall_edges = 0, acc_cyc = 0;
    int n_rd = 0, n_wr = 0, rd_idx = 0;

    fft_agu_param #(.LOG2N(LOG2N), .PIPE_LAT(PIPE_LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_fft    (start_fft),
`ifdef FFT_AGU_STALL_EN
        .stall        (stall),
`endif
        .busy         (busy),
        .rd_valid     (rd_valid),
        .rd_a_addr    (rd_a_addr),
        .rd_b_addr    (rd_b_addr),
        .twiddle_addr (twiddle_addr),
        .rd_bank      (rd_bank),
        .wr_en        (wr_en),
        .wr_a_addr    (wr_a_addr),
        .wr_b_addr    (wr_b_addr),
        .wr_bank      (wr_bank),
        .fft_done     (fft_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (!stall) ucyc++;
        if (stall) stall_edges++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int rotl5(input int x, input int s);
        return ((x << s) | (x >> (5 - s))) & 31;
    endfunction

    function automatic int twmask(input int s);
        return (15 << (4 - s)) & 15;
    endfunction

    // ---------------- monitor ----------------
    typedef struct { int a; int b; int bank; int t; int stg; } wr_exp_t;
    wr_exp_t     wq[$];
    wr_exp_t     we;
    int          wr_cnt[LOG2N];
    logic [31:0] cover_map;
    bit          dup;
    int          m_s, m_j, m_a, m_b;

    always @(negedge clk) begin
        if (!rst_n) begin
            wq.delete();
            rd_idx    = 0;
            cover_map = '0;
            dup       = 1'b0;
            foreach (wr_cnt[i]) wr_cnt[i] = 0;
        end else begin
            // reads first so a same-cycle write does not satisfy the ordering check
            if (rd_valid) begin
                if (rd_idx == NRD) rd_idx = 0;
                if (rd_idx == 0) begin
                    cover_map = '0;
                    dup       = 1'b0;
                    foreach (wr_cnt[i]) wr_cnt[i] = 0;
                end
                m_s = rd_idx / NH;
                m_j = rd_idx % NH;
                m_a = rotl5(m_j * 2, m_s);
                m_b = rotl5(m_j * 2 + 1, m_s);
                check($sformatf("rd_a s%0d j%0d", m_s, m_j), int'(rd_a_addr), m_a);
                check($sformatf("rd_b s%0d j%0d", m_s, m_j), int'(rd_b_addr), m_b);
                check($sformatf("tw s%0d j%0d", m_s, m_j), int'(twiddle_addr), m_j & twmask(m_s));
                check($sformatf("rd_bank s%0d", m_s), int'(rd_bank), m_s % 2);
                if (m_j == 0 && m_s > 0)
                    check($sformatf("order_s%0d", m_s), wr_cnt[m_s-1], NH);
                if (m_s == 2 && m_j == 5) begin
                    check("s2j5_a", int'(rd_a_addr), 9);
                    check("s2j5_b", int'(rd_b_addr), 13);
                    check("s2j5_tw", int'(twiddle_addr), 4);
                end
                if (m_s == 2 && m_j == 3) begin
                    check("s2j3_a", int'(rd_a_addr), 24);
                    check("s2j3_b", int'(rd_b_addr), 28);
                    check("s2j3_tw", int'(twiddle_addr), 0);
                end
                if (m_s == 4 && m_j == 15) begin
                    check("s4j15_a", int'(rd_a_addr), 15);
                    check("s4j15_b", int'(rd_b_addr), 31);
                    check("s4j15_tw", int'(twiddle_addr), 15);
                end
                if (cover_map[rd_a_addr] || cover_map[rd_b_addr]) dup = 1'b1;
                cover_map[rd_a_addr] = 1'b1;
                cover_map[rd_b_addr] = 1'b1;
                if (m_j == NH - 1) begin
                    check($sformatf("cover_s%0d", m_s), int'(cover_map == 32'hFFFF_FFFF), 1);
                    check($sformatf("dup_s%0d", m_s), int'(dup), 0);
                    cover_map = '0;
                    dup       = 1'b0;
                end
                wq.push_back('{m_a, m_b, m_s % 2, ucyc, m_s});
                rd_idx++;
                n_rd++;
            end
            if (wr_en) begin
                n_wr++;
                if (wq.size() == 0) begin
                    check("wr_spurious", 1, 0);
                end else begin
                    we = wq.pop_front();
                    check("wr_a", int'(wr_a_addr), we.a);
                    check("wr_b", int'(wr_b_addr), we.b);
                    check("wr_bank", int'(wr_bank), 1 - we.bank);
                    check("wr_latency", ucyc - we.t, PIPE_LAT);
                    wr_cnt[we.stg]++;
                end
            end
        end
    end

    // ---------------- sequencing helpers ----------------
    task automatic check_zero(input string tag);
        check({tag, "_busy"},     int'(busy), 0);
        check({tag, "_rd_valid"}, int'(rd_valid), 0);
        check({tag, "_rd_a"},     int'(rd_a_addr), 0);
        check({tag, "_rd_b"},     int'(rd_b_addr), 0);
        check({tag, "_tw"},       int'(twiddle_addr), 0);
        check({tag, "_rd_bank"},  int'(rd_bank), 0);
        check({tag, "_wr_en"},    int'(wr_en), 0);
        check({tag, "_wr_a"},     int'(wr_a_addr), 0);
        check({tag, "_wr_b"},     int'(wr_b_addr), 0);
        check({tag, "_wr_bank"},  int'(wr_bank), 0);
        check({tag, "_done"},     int'(fft_done), 0);
    endtask

    // Called at a negedge while idle; returns at the negedge after the accepting edge.
    task automatic start_run(input string tag);
        start_fft = 1'b1;
        @(negedge clk);
        acc_cyc     = cyc;
        stall_edges = 0;
        start_fft   = 1'b0;
        check({tag, "_busy_on_accept"}, int'(busy), 1);
    endtask

    // Length = edges from the accepting edge to the edge that captures fft_done.
    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (fft_done) begin
                seen = 1'b1;
                check({tag, "_len"}, cyc + 1 - acc_cyc, RUN_LEN + stall_edges);
                check({tag, "_busy_at_done"}, int'(busy), 1);
            end
        end
        if (!seen) check({tag, "_done_timeout"}, 0, 1);
    endtask

    task automatic finish_counts(input string tag, input int rd0, input int wr0);
        @(negedge clk);
        check({tag, "_busy_after"}, int'(busy), 0);
        check({tag, "_done_pulse"}, int'(fft_done), 0);
        repeat (8) @(negedge clk);
        check({tag, "_rd_count"}, n_rd - rd0, NRD);
        check({tag, "_wr_count"}, n_wr - wr0, NRD);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, wr0, dc;

        // reset state
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // full transform, with a start pulse mid-run that must be ignored
        rd0 = n_rd; wr0 = n_wr;
        start_run("run1");
        repeat (30) @(negedge clk);
        start_fft = 1'b1;
        @(negedge clk);
        start_fft = 1'b0;
        wait_done("run1");
        finish_counts("run1", rd0, wr0);

        // abort in the middle of stage 3
        start_run("abort");
        for (int i = 0; i < 200 && rd_idx < 3 * NH + 4; i++) @(negedge clk);
        check("abort_reached_s3", int'(rd_idx >= 3 * NH + 4), 1);
        #1 rst_n = 1'b0;
        #1 check_zero("abort");
        dc = 0;
        repeat (3) begin
            @(negedge clk);
            if (fft_done) dc++;
        end
        rst_n = 1'b1;
        repeat (120) begin
            @(negedge clk);
            if (fft_done) dc++;
        end
        check("abort_no_done", dc, 0);
        check("abort_idle_busy", int'(busy), 0);

        // fresh start after the abort
        rd0 = n_rd; wr0 = n_wr;
        start_run("rerun");
        wait_done("rerun");
        finish_counts("rerun", rd0, wr0);

        // start held high: retriggers right after DONE
        rd0 = n_rd; wr0 = n_wr;
        start_fft = 1'b1;
        @(negedge clk);
        acc_cyc = cyc;
        stall_edges = 0;
        check("held_busy_on_accept", int'(busy), 1);
        wait_done("held1");
        @(negedge clk);
        check("held_retrigger_busy", int'(busy), 1);
        check("held_done_single", int'(fft_done), 0);
        acc_cyc = cyc;
        start_fft = 1'b0;
        wait_done("held2");
        @(negedge clk);
        check("held2_busy_after", int'(busy), 0);
        repeat (8) @(negedge clk);
        check("held_rd_count", n_rd - rd0, 2 * NRD);
        check("held_wr_count", n_wr - wr0, 2 * NRD);

`ifdef FFT_AGU_STALL_EN
        // seven stall windows inside one transform
        rd0 = n_rd; wr0 = n_wr;
        start_run("stall");
        for (int w = 0; w < 7; w++) begin
            repeat ($urandom_range(8, 2)) @(posedge clk);
            #1 stall = 1'b1;
            repeat ($urandom_range(4, 1)) @(posedge clk);
            #1 stall = 1'b0;
        end
        check("stall_edges_seen", int'(stall_edges >= 7), 1);
        wait_done("stall");
        finish_counts("stall", rd0, wr0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
